// File: rtl/bsg_manycore_vcache_dma_arbiter.sv
// bsg_manycore_vcache_dma_arbiter
//
// Shares one memory-side cache-DMA channel (packet, fill data, evict data)
// among num_caches_p blocking vcaches. Packets are granted round-robin. The
// grant is held until all beats_per_block_p data beats of that transaction
// have moved. Fill data is steered to the owner and evict data is taken from
// the owner.
//
// Handshake semantics (all channels):
//   valid/ready : a beat moves in a cycle where valid and ready are both 1.
//   valid/yumi  : the consumer asserts yumi only while valid is 1, and a
//                 beat moves in that cycle. A producer may drop valid before
//                 yumi; the arbiter re-evaluates its choice every IDLE cycle.
//
// Ports
//   clk_i, reset_i           clock; asynchronous active-high reset
//   dma_pkt_i/_v_i/_yumi_o   per-cache packet requests (flattened, cache 0 in LSBs)
//   dma_data_o/_v_o/_ready_i fill data to caches (data broadcast, valid one-hot)
//   dma_data_i/_v_i/_yumi_o  evict data from caches
//   dma_pkt_o/_v_o/_yumi_i   packet to memory (MSB = write_not_read)
//   dma_data_*_mem           fill data from memory / evict data to memory
module bsg_manycore_vcache_dma_arbiter #(
  parameter int num_caches_p      = 4,
  parameter int dma_pkt_width_p   = 32,
  parameter int dma_data_width_p  = 32,
  parameter int beats_per_block_p = 2
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic [num_caches_p*dma_pkt_width_p-1:0]      dma_pkt_i,
  input  logic [num_caches_p-1:0]                      dma_pkt_v_i,
  output logic [num_caches_p-1:0]                      dma_pkt_yumi_o,
  output logic [num_caches_p*dma_data_width_p-1:0]     dma_data_o,
  output logic [num_caches_p-1:0]                      dma_data_v_o,
  input  logic [num_caches_p-1:0]                      dma_data_ready_i,
  input  logic [num_caches_p*dma_data_width_p-1:0]     dma_data_i,
  input  logic [num_caches_p-1:0]                      dma_data_v_i,
  output logic [num_caches_p-1:0]                      dma_data_yumi_o,
  output logic [dma_pkt_width_p-1:0]                   dma_pkt_o,
  output logic                                         dma_pkt_v_o,
  input  logic                                         dma_pkt_yumi_i,
  input  logic [dma_data_width_p-1:0]                  dma_data_i_mem,
  input  logic                                         dma_data_v_i_mem,
  output logic                                         dma_data_ready_o_mem,
  output logic [dma_data_width_p-1:0]                  dma_data_o_mem,
  output logic                                         dma_data_v_o_mem,
  input  logic                                         dma_data_yumi_i_mem
);

  localparam int lg_num_caches_lp = (num_caches_p > 1) ? $clog2(num_caches_p) : 1;
  localparam int lg_beats_lp      = (beats_per_block_p > 1) ? $clog2(beats_per_block_p) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_e;

  state_e                      state_r, state_n;
  logic [lg_num_caches_lp-1:0] rr_ptr_r, tag_r, sel, sel_next;
  logic [lg_beats_lp-1:0]      beat_cnt_r;

  logic [dma_pkt_width_p-1:0]  pkt_arr   [num_caches_p];
  logic [dma_data_width_p-1:0] evict_arr [num_caches_p];
  logic [dma_pkt_width_p-1:0]  pkt_sel;
  logic                        any_v, accept, beat, last_beat;
  int                          idx;

  for (genvar g = 0; g < num_caches_p; g++) begin : g_unpack
    assign pkt_arr[g]   = dma_pkt_i[g*dma_pkt_width_p +: dma_pkt_width_p];
    assign evict_arr[g] = dma_data_i[g*dma_data_width_p +: dma_data_width_p];
  end

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to rr_ptr_r (offset 0) is the one left in sel.
  always_comb begin
    sel = '0;
    idx = 0;
    for (int i = num_caches_p - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= num_caches_p) idx = idx - num_caches_p;
      if (dma_pkt_v_i[idx]) sel = lg_num_caches_lp'(idx);
    end
  end

  assign sel_next  = (int'(sel) == num_caches_p - 1) ? '0 : sel + lg_num_caches_lp'(1);
  assign any_v     = |dma_pkt_v_i;
  assign pkt_sel   = pkt_arr[sel];
  assign accept    = (state_r == IDLE) && any_v && dma_pkt_yumi_i;
  assign last_beat = (beat_cnt_r == lg_beats_lp'(beats_per_block_p - 1));
  assign beat      = ((state_r == READ)  && dma_data_v_i_mem && dma_data_ready_i[tag_r])
                  || ((state_r == WRITE) && dma_data_yumi_i_mem);

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      tag_r      <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        tag_r      <= sel;
        rr_ptr_r   <= sel_next;
        beat_cnt_r <= '0;
      end else if (beat) begin
        beat_cnt_r <= last_beat ? '0 : beat_cnt_r + lg_beats_lp'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:        if (accept) state_n = pkt_sel[dma_pkt_width_p-1] ? WRITE : READ;
      READ, WRITE: if (beat && last_beat) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  // Output logic; every handshake output is held low while reset is high,
  // including the combinational packet path.
  always_comb begin
    dma_pkt_o            = pkt_sel;
    dma_pkt_v_o          = 1'b0;
    dma_pkt_yumi_o       = '0;
    dma_data_o           = {num_caches_p{dma_data_i_mem}};
    dma_data_v_o         = '0;
    dma_data_ready_o_mem = 1'b0;
    dma_data_o_mem       = evict_arr[tag_r];
    dma_data_v_o_mem     = 1'b0;
    dma_data_yumi_o      = '0;
    if (!reset_i) begin
      case (state_r)
        IDLE: begin
          dma_pkt_v_o         = any_v;
          dma_pkt_yumi_o[sel] = accept;
        end
        READ: begin
          dma_data_v_o[tag_r]  = dma_data_v_i_mem;
          dma_data_ready_o_mem = dma_data_ready_i[tag_r];
        end
        WRITE: begin
          dma_data_v_o_mem       = dma_data_v_i[tag_r];
          dma_data_yumi_o[tag_r] = dma_data_yumi_i_mem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_manycore_vcache_dma_arbiter.sv
module tb_bsg_manycore_vcache_dma_arbiter;

  localparam int N  = 4;
  localparam int PW = 32;
  localparam int DW = 16;
  localparam int B  = 2;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [N*PW-1:0] dma_pkt_i;
  logic [N-1:0]    dma_pkt_v_i;
  logic [N-1:0]    dma_pkt_yumi_o;
  logic [N*DW-1:0] dma_data_o;
  logic [N-1:0]    dma_data_v_o;
  logic [N-1:0]    dma_data_ready_i;
  logic [N*DW-1:0] dma_data_i;
  logic [N-1:0]    dma_data_v_i;
  logic [N-1:0]    dma_data_yumi_o;
  logic [PW-1:0]   dma_pkt_o;
  logic            dma_pkt_v_o;
  logic            dma_pkt_yumi_i;
  logic [DW-1:0]   dma_data_i_mem;
  logic            dma_data_v_i_mem;
  logic            dma_data_ready_o_mem;
  logic [DW-1:0]   dma_data_o_mem;
  logic            dma_data_v_o_mem;
  logic            dma_data_yumi_i_mem;

  bsg_manycore_vcache_dma_arbiter #(
    .num_caches_p(N), .dma_pkt_width_p(PW), .dma_data_width_p(DW), .beats_per_block_p(B)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .dma_pkt_o(dma_pkt_o), .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i),
    .dma_data_i_mem(dma_data_i_mem), .dma_data_v_i_mem(dma_data_v_i_mem),
    .dma_data_ready_o_mem(dma_data_ready_o_mem), .dma_data_o_mem(dma_data_o_mem),
    .dma_data_v_o_mem(dma_data_v_o_mem), .dma_data_yumi_i_mem(dma_data_yumi_i_mem)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Scoreboard queues: {yumi mask, pkt}, {cache idx, fill data}, {yumi mask, evict data}
  logic [N+PW-1:0] exp_pkt_q[$];
  logic [DW+1:0]   exp_fill_q[$];
  logic [N+DW-1:0] exp_evict_q[$];

  int   checks   = 0;
  int   failures = 0;
  int   timeouts = 0;
  logic [1:0] busy_exp = 2'd0;  // 0 idle, 1 read, 2 write (bench model)
  logic done = 1'b0;

  // Driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_pkt(input int c, input logic [PW-1:0] p);
    dma_pkt_i[c*PW +: PW] = p;
  endtask

  task automatic accept(input logic [N-1:0] mask, input logic [PW-1:0] p, input logic [1:0] kind);
    int n = 0;
    exp_pkt_q.push_back({mask, p});
    while (!dma_pkt_v_o && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      timeouts++;
      $display("FAIL pkt_wait: dma_pkt_v_o never rose, required 1");
    end
    dma_pkt_yumi_i = 1'b1;
    step();
    dma_pkt_yumi_i = 1'b0;
    dma_pkt_v_i    = dma_pkt_v_i & ~mask;
    busy_exp       = kind;
  endtask

  task automatic fill(input int c, input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit bp);
    int k = 0;
    int n = 0;
    logic xfer;
    exp_fill_q.push_back({2'(c), d0});
    exp_fill_q.push_back({2'(c), d1});
    while (k < B && n < 200) begin
      if (bp) begin
        dma_data_v_i_mem = 1'($urandom_range(0, 1));
        dma_data_ready_i = 4'($urandom_range(0, 15));
      end else begin
        dma_data_v_i_mem = 1'b1;
        dma_data_ready_i = '1;
      end
      dma_data_i_mem = (k == 0) ? d0 : d1;
      @(negedge clk_i);
      xfer = dma_data_v_i_mem && dma_data_ready_o_mem;
      step();
      if (xfer) k++;
      n++;
    end
    if (k < B) begin
      timeouts++;
      $display("FAIL fill_wait: beats moved=%0d required=%0d", k, B);
    end
    dma_data_v_i_mem = 1'b0;
    dma_data_ready_i = '0;
    busy_exp = 2'd0;
  endtask

  task automatic evict(input int c, input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int nb);
    for (int k = 0; k < nb; k++) begin
      exp_evict_q.push_back({4'(1 << c), (k == 0) ? d0 : d1});
      dma_data_i = {N{16'hEEEE}};
      dma_data_v_i = '1;  // other caches also offer data; only the owner may be taken
      dma_data_i[c*DW +: DW] = (k == 0) ? d0 : d1;
      dma_data_yumi_i_mem = 1'b1;
      step();
    end
    dma_data_yumi_i_mem = 1'b0;
    dma_data_v_i = '0;
    if (nb == B) busy_exp = 2'd0;
  endtask

  // Monitor: pops and compares whenever a transfer is seen
  logic [N+PW-1:0] e_pkt;
  logic [DW+1:0]   e_fill;
  logic [N+DW-1:0] e_ev;
  int              e_idx;

  always @(negedge clk_i) begin
    if (done) begin
      checks++; if (exp_pkt_q.size() != 0)   begin failures++; $display("FAIL pkt_q_drain: left=%0d required=0", exp_pkt_q.size()); end
      checks++; if (exp_fill_q.size() != 0)  begin failures++; $display("FAIL fill_q_drain: left=%0d required=0", exp_fill_q.size()); end
      checks++; if (exp_evict_q.size() != 0) begin failures++; $display("FAIL evict_q_drain: left=%0d required=0", exp_evict_q.size()); end
      checks++; if (timeouts != 0)           begin failures++; $display("FAIL timeouts: got=%0d required=0", timeouts); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (reset_i) begin
      checks++;
      if ({dma_pkt_v_o, dma_pkt_yumi_o, dma_data_v_o, dma_data_ready_o_mem, dma_data_v_o_mem, dma_data_yumi_o} !== '0) begin
        failures++;
        $display("FAIL reset_quiet: pkt_v=%b pkt_yumi=%b data_v=%b rdy_mem=%b v_mem=%b data_yumi=%b required all 0",
                 dma_pkt_v_o, dma_pkt_yumi_o, dma_data_v_o, dma_data_ready_o_mem, dma_data_v_o_mem, dma_data_yumi_o);
      end
    end else begin
      if (busy_exp == 2'd0) begin
        checks++;
        if (dma_pkt_v_o !== (|dma_pkt_v_i)) begin failures++; $display("FAIL idle_pkt_v: got=%b required=%b", dma_pkt_v_o, |dma_pkt_v_i); end
        checks++;
        if ({dma_data_v_o, dma_data_ready_o_mem, dma_data_v_o_mem, dma_data_yumi_o} !== '0) begin
          failures++;
          $display("FAIL idle_data_quiet: data_v=%b rdy_mem=%b v_mem=%b data_yumi=%b required 0", dma_data_v_o, dma_data_ready_o_mem, dma_data_v_o_mem, dma_data_yumi_o);
        end
        if (dma_pkt_yumi_i) begin
          checks++;
          if (exp_pkt_q.size() == 0) begin
            failures++; $display("FAIL pkt_unexpected: pkt=%h yumi=%b required no transfer", dma_pkt_o, dma_pkt_yumi_o);
          end else begin
            e_pkt = exp_pkt_q.pop_front();
            if (dma_pkt_v_o !== 1'b1 || dma_pkt_o !== e_pkt[PW-1:0] || dma_pkt_yumi_o !== e_pkt[N+PW-1:PW]) begin
              failures++;
              $display("FAIL pkt_grant: v=%b pkt=%h yumi=%b required v=1 pkt=%h yumi=%b", dma_pkt_v_o, dma_pkt_o, dma_pkt_yumi_o, e_pkt[PW-1:0], e_pkt[N+PW-1:PW]);
            end
          end
        end else begin
          checks++;
          if (dma_pkt_yumi_o !== '0) begin failures++; $display("FAIL idle_pkt_yumi: got=%b required=0", dma_pkt_yumi_o); end
        end
      end else begin
        checks++;
        if (dma_pkt_v_o !== 1'b0 || dma_pkt_yumi_o !== '0) begin
          failures++; $display("FAIL busy_pkt_quiet: v=%b yumi=%b required 0", dma_pkt_v_o, dma_pkt_yumi_o);
        end
        if (busy_exp == 2'd1) begin
          checks++;
          if (dma_data_v_o_mem !== 1'b0 || dma_data_yumi_o !== '0) begin
            failures++; $display("FAIL read_evict_quiet: v_mem=%b data_yumi=%b required 0", dma_data_v_o_mem, dma_data_yumi_o);
          end
          if (dma_data_v_i_mem && dma_data_ready_o_mem) begin
            checks++;
            if (exp_fill_q.size() == 0) begin
              failures++; $display("FAIL fill_unexpected: data=%h required no beat", dma_data_i_mem);
            end else begin
              e_fill = exp_fill_q.pop_front();
              e_idx  = int'(e_fill[DW+1:DW]);
              if (dma_data_v_o !== 4'(1 << e_idx) || dma_data_o[e_idx*DW +: DW] !== e_fill[DW-1:0]) begin
                failures++;
                $display("FAIL fill_beat: data_v=%b data=%h required data_v=%b data=%h", dma_data_v_o, dma_data_o[e_idx*DW +: DW], 4'(1 << e_idx), e_fill[DW-1:0]);
              end
            end
          end
        end else begin
          checks++;
          if (dma_data_v_o !== '0 || dma_data_ready_o_mem !== 1'b0) begin
            failures++; $display("FAIL write_fill_quiet: data_v=%b rdy_mem=%b required 0", dma_data_v_o, dma_data_ready_o_mem);
          end
          if (dma_data_yumi_i_mem) begin
            checks++;
            if (exp_evict_q.size() == 0) begin
              failures++; $display("FAIL evict_unexpected: data=%h required no beat", dma_data_o_mem);
            end else begin
              e_ev = exp_evict_q.pop_front();
              if (dma_data_v_o_mem !== 1'b1 || dma_data_o_mem !== e_ev[DW-1:0] || dma_data_yumi_o !== e_ev[N+DW-1:DW]) begin
                failures++;
                $display("FAIL evict_beat: v=%b data=%h yumi=%b required v=1 data=%h yumi=%b", dma_data_v_o_mem, dma_data_o_mem, dma_data_yumi_o, e_ev[DW-1:0], e_ev[N+DW-1:DW]);
              end
            end
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    reset_i = 1'b1;
    dma_pkt_i = '0; dma_pkt_v_i = '0; dma_data_ready_i = '0;
    dma_data_i = '0; dma_data_v_i = '0; dma_pkt_yumi_i = 1'b0;
    dma_data_i_mem = '0; dma_data_v_i_mem = 1'b0; dma_data_yumi_i_mem = 1'b0;
    step(); step();
    reset_i = 1'b0;
    step();

    // Single read from cache 2; rr_ptr becomes 3
    set_pkt(2, 32'h0000_1000);
    dma_pkt_v_i = 4'b0100;
    accept(4'b0100, 32'h0000_1000, 2'd1);
    set_pkt(0, 32'h0000_0A00);
    set_pkt(3, 32'h0000_3A00);
    dma_pkt_v_i = 4'b1001;  // new requests must wait while READ is busy
    fill(2, 16'h000A, 16'h000B, 1'b0);

    // rr_ptr=3: cache 3 wins over cache 0, then cache 0
    accept(4'b1000, 32'h0000_3A00, 2'd1);
    fill(3, 16'h0031, 16'h0032, 1'b0);
    accept(4'b0001, 32'h0000_0A00, 2'd1);
    fill(0, 16'h0001, 16'h0002, 1'b0);

    // Single write from cache 1
    set_pkt(1, 32'h8000_2000);
    dma_pkt_v_i = 4'b0010;
    accept(4'b0010, 32'h8000_2000, 2'd2);
    evict(1, 16'h0011, 16'h0022, 2);
    step();

    // All four request continuously from reset: grant order 0,1,2,3,0
    for (int c = 0; c < N; c++) set_pkt(c, 32'h0004_0000 + 32'(c) * 32'h10);
    dma_pkt_v_i = '1;
    reset_i = 1'b1;
    busy_exp = 2'd0;
    step(); step();
    reset_i = 1'b0;
    for (int t = 0; t < 5; t++) begin
      dma_pkt_v_i = '1;
      accept(4'(1 << (t % N)), 32'h0004_0000 + 32'(t % N) * 32'h10, 2'd1);
      fill(t % N, 16'(16'h0100 * t), 16'(16'h0100 * t + 1), 1'b0);
    end
    dma_pkt_v_i = '0;
    step();

    // Backpressured read from cache 1 (rr_ptr=1)
    set_pkt(1, 32'h0000_5000);
    dma_pkt_v_i = 4'b0010;
    accept(4'b0010, 32'h0000_5000, 2'd1);
    fill(1, 16'h0050, 16'h0051, 1'b1);
    dma_data_v_i_mem = 1'b1;  // memory keeps offering; IDLE must not take it
    dma_data_ready_i = '1;
    step(); step();
    dma_data_v_i_mem = 1'b0;
    dma_data_ready_i = '0;

    // Write from cache 2, reset after first beat
    set_pkt(2, 32'h8000_3000);
    dma_pkt_v_i = 4'b0100;
    accept(4'b0100, 32'h8000_3000, 2'd2);
    evict(2, 16'h0033, 16'h0044, 1);
    dma_data_v_i = '1;
    dma_data_yumi_i_mem = 1'b1;
    dma_pkt_v_i = '1;
    dma_pkt_yumi_i = 1'b1;
    reset_i = 1'b1;
    busy_exp = 2'd0;
    step(); step();
    dma_data_v_i = '0;
    dma_data_yumi_i_mem = 1'b0;
    dma_pkt_v_i = '0;
    dma_pkt_yumi_i = 1'b0;
    reset_i = 1'b0;
    step();

    // After reset, cache 3 alone is granted and completes
    set_pkt(3, 32'h0000_7000);
    dma_pkt_v_i = 4'b1000;
    accept(4'b1000, 32'h0000_7000, 2'd1);
    fill(3, 16'h0070, 16'h0071, 1'b0);
    step(); step();
    done = 1'b1;
  end

endmodule
